// File: rtl/mcdt_pkg.sv
// Shared MCDT datapath definitions: word and channel-id widths, FIFO sizing,
// and the record the bench and downstream logic use for a popped word.
package mcdt_pkg;

   localparam int DATA_W     = 32;
   localparam int CH_ID_W    = 2;
   localparam int FIFO_DEPTH = 32;
   localparam int MARGIN_W   = 6;
   localparam int ACC_W      = 16;

   typedef logic [DATA_W-1:0]  data_t;
   typedef logic [CH_ID_W-1:0] ch_id_t;
   typedef logic [ACC_W-1:0]   acc_t;

   // A word as presented to the arbiter: payload plus originating channel.
   typedef struct packed {
      ch_id_t id;
      data_t  data;
   } tagged_word_t;

endpackage : mcdt_pkg

// File: rtl/chnl_rx_mem.sv
// Channel receive storage: simple dual-port register array with a synchronous
// write port and a synchronous, registered read port (one-cycle read latency).
module chnl_rx_mem
   import mcdt_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  data_t         wr_data_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   output data_t         rd_data_o
);

   data_t mem_q [DEPTH];
   data_t rd_data_q;

   // Write port: store the accepted word at the write address.
   // NOTE: the array is deliberately not reset; its contents are don't-care
   // after reset because the pointers and count define what is valid, and
   // leaving it unreset lets it map onto plain storage cells.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Read port: register the addressed word on a pop; cleared by reset so the
   // arbiter never sees stale data after a channel flush.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of block order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule : chnl_rx_mem

// File: rtl/chnl_rx_fifo.sv
// Channel receive FIFO: accepts words from a channel master over valid/ready,
// buffers them, advertises free space, and hands them to the arbiter through a
// request/pop port with one-cycle read latency. Each popped word carries CH_ID.
module chnl_rx_fifo
   import mcdt_pkg::*;
#(
   parameter int CH_ID = 0,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [DATA_W-1:0]   ch_data_i,
   input  logic                ch_valid_i,
   output logic                ch_ready_o,
   output logic [MARGIN_W-1:0] ch_margin_o,
   output logic                a_req_o,
   input  logic                a_rd_i,
   output logic [DATA_W-1:0]   a_data_o,
   output logic [CH_ID_W-1:0]  a_id_o,
   output logic                a_val_o,
   output logic [ACC_W-1:0]    acc_cnt_o,
   output logic                ovf_o
);

   localparam int                  AW        = $clog2(DEPTH);
   localparam logic [MARGIN_W-1:0] DEPTH_CNT = MARGIN_W'(DEPTH);
   localparam ch_id_t              MY_ID     = CH_ID_W'(CH_ID);

   logic [AW-1:0]       wr_ptr_q;
   logic [AW-1:0]       rd_ptr_q;
   logic [MARGIN_W-1:0] count_q;
   logic [MARGIN_W-1:0] count_nxt;
   acc_t                acc_cnt_q;
   logic                ovf_q;
   logic                a_val_q;
   ch_id_t              a_id_q;
   data_t               rd_data;

   logic push;
   logic pop;

   // Handshake status comes from the count register only, so there is no
   // combinational path from any input to ready, margin or request.
   assign ch_ready_o  = (count_q != DEPTH_CNT);
   assign a_req_o     = (count_q != '0);
   assign ch_margin_o = DEPTH_CNT - count_q;

   // A push needs room; a pop needs a stored word. A word pushed into an empty
   // FIFO is therefore not poppable until the following cycle.
   assign push = ch_valid_i && ch_ready_o;
   assign pop  = a_rd_i && a_req_o;

   chnl_rx_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (push),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (ch_data_i),
      .rd_en_i   (pop),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   // Pointer advance; both wrap naturally at the power-of-two depth.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Occupancy update: simultaneous push and pop leave the count unchanged.
   // NOTE: count_nxt gets a default before the case so every path assigns it
   // and no latch is inferred.
   always_comb begin
      count_nxt = count_q;
      unique case ({push, pop})
         2'b10:   count_nxt = count_q + MARGIN_W'(1);
         2'b01:   count_nxt = count_q - MARGIN_W'(1);
         default: count_nxt = count_q;
      endcase
   end

   // Occupancy register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_nxt;
      end
   end

   // Accepted-word counter (free-running wrap) and sticky overflow flag, which
   // records a master presenting valid while the FIFO was full.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_cnt_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         if (push) begin
            acc_cnt_q <= acc_cnt_q + ACC_W'(1);
         end
         if (ch_valid_i && !ch_ready_o) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Pop-side qualifiers aligned with the registered read data.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_val_q <= 1'b0;
         a_id_q  <= '0;
      end else begin
         a_val_q <= pop;
         if (pop) begin
            a_id_q <= MY_ID;
         end
      end
   end

   assign a_data_o  = rd_data;
   assign a_id_o    = a_id_q;
   assign a_val_o   = a_val_q;
   assign acc_cnt_o = acc_cnt_q;
   assign ovf_o     = ovf_q;

endmodule : chnl_rx_fifo
